// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the integer divide sequencer.
// Holds the FSM encoding, the iteration count and the layout of the result bus returned to EX.
package div_sequencer_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  localparam int DIV_ITER     = 32;
  localparam int DIV_TO_EX_WD = 66;

  // Result bus toward EX, {done, div_zero, quotient, remainder}.
  function automatic logic [DIV_TO_EX_WD-1:0] pack_to_ex(
    input logic        done,
    input logic        div_zero,
    input logic [31:0] q,
    input logic [31:0] r
  );
    return {done, div_zero, q, r};
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor when the result stays non-negative.
module div_iter_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_shifted = {rem[WIDTH-1:0], dvd_msb};
  assign w_trial   = w_shifted - {1'b0, dvs};
  // A set rem MSB would shift out a value larger than any divisor, so it always fits.
  assign w_fits    = rem[WIDTH] | (w_shifted >= {1'b0, dvs});

  // Choose between the restored and the subtracted remainder.
  always_comb begin
    rem_next = w_shifted;
    q_bit    = 1'b0;
    if (w_fits) begin
      rem_next = w_trial;
      q_bit    = 1'b1;
    end else begin
      rem_next = w_shifted;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the EX stage: one restoring step per cycle,
// holds the pipeline through stallreq and returns quotient/remainder with a done pulse.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int             CW   = $clog2(ITER);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  div_state_e       r_state;
  logic             r_signed;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic             r_done;
  logic             r_busy;

  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .dvd_msb  (r_dvd[WIDTH-1]),
    .dvs      (r_dvs),
    .rem_next (w_rem_next),
    .q_bit    (w_q_bit)
  );

  // Magnitudes for PREP and sign-corrected results for FIX.
  always_comb begin
    w_dvd_abs = r_dvd;
    w_dvs_abs = r_dvs;
    w_quo_fix = r_dvd;
    w_rem_fix = r_rem[WIDTH-1:0];
    if (r_signed && r_dvd[WIDTH-1]) begin
      w_dvd_abs = ~r_dvd + ONE;
    end else begin
      w_dvd_abs = r_dvd;
    end
    if (r_signed && r_dvs[WIDTH-1]) begin
      w_dvs_abs = ~r_dvs + ONE;
    end else begin
      w_dvs_abs = r_dvs;
    end
    if (r_q_neg) begin
      w_quo_fix = ~r_dvd + ONE;
    end else begin
      w_quo_fix = r_dvd;
    end
    if (r_r_neg) begin
      w_rem_fix = ~r_rem[WIDTH-1:0] + ONE;
    end else begin
      w_rem_fix = r_rem[WIDTH-1:0];
    end
  end

  // Sequencer FSM; quotient bits shift into r_dvd as dividend bits shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DIV_IDLE;
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dvd       <= ZERO;
      r_dvs       <= ZERO;
      r_rem       <= {(WIDTH+1){1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_quotient  <= ZERO;
      r_remainder <= ZERO;
      r_div_zero  <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (cancel) begin
      r_state    <= DIV_IDLE;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_signed <= is_signed;
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_busy   <= 1'b1;
            r_state  <= DIV_PREP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= DIV_IDLE;
          end
        end
        DIV_PREP: begin
          r_q_neg <= r_signed & (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
          r_r_neg <= r_signed & r_dvd[WIDTH-1];
          r_rem   <= {(WIDTH+1){1'b0}};
          r_cnt   <= {CW{1'b0}};
          if (r_dvs == ZERO) begin
            r_quotient  <= {WIDTH{1'b1}};
            r_remainder <= r_dvd;
            r_div_zero  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DIV_DONE;
          end else begin
            r_dvd      <= w_dvd_abs;
            r_dvs      <= w_dvs_abs;
            r_div_zero <= 1'b0;
            r_state    <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= DIV_FIX;
          end else begin
            r_state <= DIV_RUN;
          end
        end
        DIV_FIX: begin
          r_quotient  <= w_quo_fix;
          r_remainder <= w_rem_fix;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DIV_DONE;
        end
        DIV_DONE: begin
          r_done  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign stallreq  = ((r_state == DIV_IDLE) & start) | r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule
